// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Decides when a decoded instruction may move into a one-entry registered
//   issue slot. It tracks pending destination registers, limits the number of
//   outstanding loads, stalls behind unresolved branches/jumps and halts on an
//   illegal op code.
//
//   Optional feature macro: ISSUE_BYPASS_EN
//     defined   : a same-cycle writeback clears the hazard check, so a dependent
//                 instruction can issue in the writeback cycle
//     undefined : the hazard check uses only the registered scoreboard
//
//   Ports
//     clk, rst                         clock, synchronous active-high reset
//     dec_valid/dec_ready              decoder handshake
//     dec_rs1i/rs2i/rdi/imm/code       decoded fields (code 12'hFFF = illegal)
//     dec_isLoad/dec_isBranch          instruction class
//     iss_valid/iss_ready              issue slot handshake
//     iss_rs1i/rs2i/rdi/imm/code/isLoad registered copy of accepted fields
//     wb_valid/wb_rdi/wb_isLoad        writeback from execute
//     br_valid/br_taken                branch resolution from execute
//     flush                            one-cycle redirect pulse
//     illegal                          sticky illegal-instruction flag
//     pending                          scoreboard, bit 0 always 0
//
//   state   | meaning
//   RUN     | normal issue
//   BR_WAIT | branch issued, waiting for resolution, no issue
//   HALT    | illegal instruction seen, left only through reset
module issue_scheduler #(
    parameter int MAX_LOADS = 4,
    parameter int LDCW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rs1i,
    input  logic [4:0]  dec_rs2i,
    input  logic [4:0]  dec_rdi,
    input  logic [31:0] dec_imm,
    input  logic [11:0] dec_code,
    input  logic        dec_isLoad,
    input  logic        dec_isBranch,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [4:0]  iss_rs1i,
    output logic [4:0]  iss_rs2i,
    output logic [4:0]  iss_rdi,
    output logic [31:0] iss_imm,
    output logic [11:0] iss_code,
    output logic        iss_isLoad,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rdi,
    input  logic        wb_isLoad,
    input  logic        br_valid,
    input  logic        br_taken,
    output logic        flush,
    output logic        illegal,
    output logic [31:0] pending
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LDCW-1:0] ldcnt;
    logic [31:0]     wb_mask;
    logic [31:0]     set_mask;
    logic [31:0]     pend_eff;
    logic            is_illegal;
    logic            ld_full;
    logic            hz;
    logic            accept;
    logic            ld_inc;
    logic            ld_dec;

    // Register 0 is never tracked, so neither mask may touch bit 0.
    always_comb begin
        wb_mask = '0;
        if (wb_valid && wb_rdi != 5'd0)
            wb_mask[wb_rdi] = 1'b1;
    end

    always_comb begin
        set_mask = '0;
        if (accept && dec_rdi != 5'd0)
            set_mask[dec_rdi] = 1'b1;
    end

`ifdef ISSUE_BYPASS_EN
    assign pend_eff = pending & ~wb_mask;
`else
    assign pend_eff = pending;
`endif

    assign is_illegal = (dec_code == 12'hFFF);
    assign ld_full    = (ldcnt == LDCW'(MAX_LOADS));
    assign hz         = pend_eff[dec_rs1i] | pend_eff[dec_rs2i] | pend_eff[dec_rdi]
                      | (dec_isLoad & ld_full);
    assign dec_ready  = !rst && (state == RUN) && (!iss_valid || iss_ready)
                      && !is_illegal && !hz;
    assign accept     = dec_valid & dec_ready;
    assign ld_inc     = accept & dec_isLoad;
    assign ld_dec     = wb_valid & wb_isLoad;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (dec_valid && is_illegal)
                    state_nxt = HALT;
                else if (accept && dec_isBranch)
                    state_nxt = BR_WAIT;
            end
            BR_WAIT: begin
                if (br_valid)
                    state_nxt = RUN;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_rs1i   <= '0;
            iss_rs2i   <= '0;
            iss_rdi    <= '0;
            iss_imm    <= '0;
            iss_code   <= '0;
            iss_isLoad <= 1'b0;
            flush      <= 1'b0;
            illegal    <= 1'b0;
            pending    <= '0;
            ldcnt      <= '0;
        end else begin
            if (accept) begin
                iss_valid  <= 1'b1;
                iss_rs1i   <= dec_rs1i;
                iss_rs2i   <= dec_rs2i;
                iss_rdi    <= dec_rdi;
                iss_imm    <= dec_imm;
                iss_code   <= dec_code;
                iss_isLoad <= dec_isLoad;
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end

            flush   <= (state == BR_WAIT) && br_valid && br_taken;
            illegal <= illegal | ((state == RUN) && dec_valid && is_illegal);
            // Set is applied after clear so a same-cycle set wins.
            pending <= (pending & ~wb_mask) | set_mask;

            // Simultaneous load accept and load writeback cancel out; a
            // writeback at zero is treated as spurious and holds zero.
            case ({ld_inc, ld_dec})
                2'b10:   ldcnt <= ldcnt + LDCW'(1);
                2'b01:   if (ldcnt != '0) ldcnt <= ldcnt - LDCW'(1);
                default: ldcnt <= ldcnt;
            endcase
        end
    end

endmodule
